// File: rtl/mse_gpio_bank.sv
// Parametrised GPIO port bank: per-port OUT/DIR/IN/EDGE registers on the internal bus and a prescaled counter pattern generator.
// Optional edge-detect interrupt logic is enabled by defining MSE_GPIO_EDGE_IRQ_EN.
module mse_gpio_bank #(
    parameter int NPORTS      = 10,
    parameter int PW          = 8,
    parameter int DW          = 16,
    parameter bit PATTERN_RST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           address,
    input  logic [DW-1:0]        wdata,
    input  logic                 wr,
    input  logic                 rd,
    output logic [DW-1:0]        rdata,
    output logic                 rd_valid,
    input  logic [NPORTS*PW-1:0] port_in,
    output logic [NPORTS*PW-1:0] port_out,
    output logic [NPORTS*PW-1:0] port_oe,
    output logic                 irq
);

    logic [5:0]    idx;
    logic [1:0]    sel;
    logic          is_global;

    logic [PW-1:0] out_reg [NPORTS];
    logic [PW-1:0] dir_reg [NPORTS];
    logic [PW-1:0] sync1   [NPORTS];
    logic [PW-1:0] sync2   [NPORTS];

    logic          pattern_en;
    logic [7:0]    prescale;
    logic [7:0]    pre_cnt;
    logic [7:0]    pat_cnt;
    logic [PW-1:0] pat_val;

    logic [PW-1:0] rd_port;
    logic [DW-1:0] rd_next;

`ifdef MSE_GPIO_EDGE_IRQ_EN
    logic [PW-1:0]     sync2_d  [NPORTS];
    logic [PW-1:0]     edge_sts [NPORTS];
    logic [NPORTS-1:0] irq_mask;
    logic              irq_next;
`endif

    assign idx       = address[7:2];
    assign sel       = address[1:0];
    assign is_global = (idx == 6'h3F);

    // Pattern value is the low PW bits of the 8-bit counter, zero-extended for wide ports
    always_comb begin
        pat_val = '0;
        for (int i = 0; i < PW; i++) begin
            if (i < 8) pat_val[i] = pat_cnt[i % 8];
        end
    end

    always_comb begin
        port_out = '0;
        port_oe  = '0;
        for (int k = 0; k < NPORTS; k++) begin
            port_out[k*PW +: PW] = pattern_en ? pat_val : out_reg[k];
            port_oe[k*PW +: PW]  = pattern_en ? {PW{1'b1}} : dir_reg[k];
        end
    end

    always_comb begin
        rd_port = '0;
        rd_next = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (idx == 6'(k)) begin
                case (sel)
                    2'd0: rd_port = out_reg[k];
                    2'd1: rd_port = dir_reg[k];
                    2'd2: rd_port = sync2[k];
`ifdef MSE_GPIO_EDGE_IRQ_EN
                    default: rd_port = edge_sts[k];
`else
                    default: rd_port = '0;
`endif
                endcase
            end
        end
        for (int i = 0; i < DW; i++) begin
            if (i < PW) rd_next[i] = rd_port[i % PW];
        end
        if (is_global) begin
            case (sel)
                2'd0: begin
                    rd_next[0]    = pattern_en;
                    rd_next[15:8] = prescale;
                end
                2'd1: rd_next[7:0] = pat_cnt;
`ifdef MSE_GPIO_EDGE_IRQ_EN
                2'd2: begin
                    for (int k = 0; k < NPORTS; k++) begin
                        if (k < DW) rd_next[k % DW] = irq_mask[k];
                    end
                end
`endif
                default: rd_next = '0;
            endcase
        end
    end

`ifdef MSE_GPIO_EDGE_IRQ_EN
    always_comb begin
        irq_next = 1'b0;
        for (int k = 0; k < NPORTS; k++) begin
            if ((|edge_sts[k]) && irq_mask[k]) irq_next = 1'b1;
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NPORTS; k++) begin
                out_reg[k] <= '0;
                dir_reg[k] <= '0;
                sync1[k]   <= '0;
                sync2[k]   <= '0;
            end
            pattern_en <= PATTERN_RST;
            prescale   <= '0;
            pre_cnt    <= '0;
            pat_cnt    <= '0;
            rdata      <= '0;
            rd_valid   <= 1'b0;
        end else begin
            // Counters only run while the pattern is enabled, and restart from zero when it is re-enabled
            if (!pattern_en) begin
                pre_cnt <= '0;
                pat_cnt <= '0;
            end else if (pre_cnt == prescale) begin
                pre_cnt <= '0;
                pat_cnt <= pat_cnt + 8'd1;
            end else begin
                pre_cnt <= pre_cnt + 8'd1;
            end

            rd_valid <= rd;
            if (rd) rdata <= rd_next;

            for (int k = 0; k < NPORTS; k++) begin
                sync1[k] <= port_in[k*PW +: PW];
                sync2[k] <= sync1[k];
                if (wr && idx == 6'(k)) begin
                    if (sel == 2'd0) out_reg[k] <= wdata[PW-1:0];
                    if (sel == 2'd1) dir_reg[k] <= wdata[PW-1:0];
                end
            end

            if (wr && is_global && sel == 2'd0) begin
                pattern_en <= wdata[0];
                prescale   <= wdata[15:8];
            end
        end
    end

`ifdef MSE_GPIO_EDGE_IRQ_EN
    // A rising edge seen in the same cycle as a W1C write keeps the bit set
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NPORTS; k++) begin
                sync2_d[k]  <= '0;
                edge_sts[k] <= '0;
            end
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            for (int k = 0; k < NPORTS; k++) begin
                sync2_d[k]  <= sync2[k];
                edge_sts[k] <= (edge_sts[k] & ~((wr && idx == 6'(k) && sel == 2'd3) ? wdata[PW-1:0] : {PW{1'b0}}))
                             | (sync2[k] & ~sync2_d[k] & ~dir_reg[k]);
            end
            if (wr && is_global && sel == 2'd2) begin
                for (int k = 0; k < NPORTS; k++) begin
                    if (k < DW) irq_mask[k] <= wdata[k % DW];
                end
            end
            irq <= irq_next;
        end
    end
`endif

endmodule
